// File: rtl/mmse_sched_pkg.sv
// mmse_sched_pkg: shared types and per-symbol constants for the PBCH DMRS MMSE scheduler.
//   state_e    FSM state encoding
//   SYM_BASE   LSE buffer base address of each DMRS symbol
//   SYM_LEN    pilot estimates fetched per symbol
//   SYM_OUT    equalised outputs expected per symbol
//   EQ_TOTAL   outputs per SSB
package mmse_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StCheck,
        StGap,
        StDone
    } state_e;

    // Element [n] belongs to symbol n.
    localparam logic [3:0][7:0] SYM_BASE = {8'd84, 8'd72, 8'd60, 8'd0};
    localparam logic [3:0][7:0] SYM_LEN  = {8'd60, 8'd12, 8'd12, 8'd60};
    localparam logic [3:0][9:0] SYM_OUT  = {10'd240, 10'd48, 10'd48, 10'd240};

    localparam int unsigned EQ_TOTAL = 576;

endpackage

// File: rtl/mmse_sched_timer.sv
// mmse_sched_timer: WAIT-state watchdog, built only with MMSE_SCHED_TIMEOUT_EN.
//   clk      clock
//   rst      asynchronous active-low reset
//   run      high while the scheduler is in WAIT; low clears the count
//   expired  high once run has lasted TIMEOUT_CYCLES cycles
module mmse_sched_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 2048
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;

    assign expired = run && (cnt_q == CntW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (!run) begin
            cnt_q <= '0;
        end else if (!expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mmse_scheduler.sv
// mmse_scheduler: steps the four PBCH DMRS symbols of one SSB through the MMSE engine.
// Fetches each symbol's LSE pilots, streams them to the engine tagged with the symbol number,
// then counts the engine's outputs and hands out channel-estimate buffer write addresses.
//   clk, rst                       clock, asynchronous active-low reset
//   start                          one-cycle pulse, begins an SSB (accepted only in IDLE)
//   lse_rd_en/lse_rd_addr          LSE buffer read port; lse_rd_i/q valid one cycle later
//   mmse_h_i/q, mmse_in_valid      sample stream to the engine, mmse_symbol_num its symbol
//   mmse_out_valid/symbol_done     engine output strobe and end-of-symbol pulse
//   eq_wr_en/eq_wr_addr            channel-estimate buffer write port
//   busy, done, err                status; err is sticky until the next accepted start
// Build option: MMSE_SCHED_TIMEOUT_EN adds a WAIT watchdog that abandons a stalled SSB.
import mmse_sched_pkg::*;

module mmse_scheduler #(
    parameter int unsigned LSE_WORD_LENGTH = 8,
    parameter int unsigned LSE_ADDR_WIDTH  = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 2048
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       lse_rd_en,
    output logic [LSE_ADDR_WIDTH-1:0]  lse_rd_addr,
    input  logic [LSE_WORD_LENGTH-1:0] lse_rd_i,
    input  logic [LSE_WORD_LENGTH-1:0] lse_rd_q,
    output logic [LSE_WORD_LENGTH-1:0] mmse_h_i,
    output logic [LSE_WORD_LENGTH-1:0] mmse_h_q,
    output logic                       mmse_in_valid,
    output logic [1:0]                 mmse_symbol_num,
    input  logic                       mmse_out_valid,
    input  logic                       mmse_symbol_done,
    output logic                       eq_wr_en,
    output logic [9:0]                 eq_wr_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    state_e                    state_q, state_d;
    logic [1:0]                sym_q, sym_d;
    logic                      rd_en_q, rd_en_d;
    logic [LSE_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]                fetch_cnt_q, fetch_cnt_d;
    logic [9:0]                out_cnt_q, out_cnt_d;
    logic [9:0]                eq_addr_q, eq_addr_d;
    logic                      gap_q, gap_d;
    logic                      in_valid_q;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      timeout;
    logic                      wr_en;

`ifdef MMSE_SCHED_TIMEOUT_EN
    mmse_sched_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (state_q == StWait),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Engine outputs only count while waiting for the current symbol.
    assign wr_en = mmse_out_valid && (state_q == StWait);

    always_comb begin
        state_d     = state_q;
        sym_d       = sym_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        fetch_cnt_d = fetch_cnt_q;
        out_cnt_d   = out_cnt_q;
        eq_addr_d   = eq_addr_q;
        gap_d       = gap_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;

        // Saturate rather than wrap if the engine over-delivers.
        if (wr_en) begin
            if (out_cnt_q != '1) out_cnt_d = out_cnt_q + 1'b1;
            if (eq_addr_q != '1) eq_addr_d = eq_addr_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StFetch;
                    sym_d       = 2'd0;
                    rd_en_d     = 1'b1;
                    rd_addr_d   = LSE_ADDR_WIDTH'(SYM_BASE[0]);
                    fetch_cnt_d = '0;
                    out_cnt_d   = '0;
                    eq_addr_d   = '0;
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                end
            end
            StFetch: begin
                fetch_cnt_d = fetch_cnt_q + 1'b1;
                if (fetch_cnt_q == SYM_LEN[sym_q] - 8'd1) begin
                    state_d = StWait;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            StWait: begin
                if (mmse_symbol_done) begin
                    state_d = StCheck;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StCheck: begin
                if (out_cnt_q != SYM_OUT[sym_q]) err_d = 1'b1;
                if (sym_q == 2'd3) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    state_d = StGap;
                    sym_d   = sym_q + 2'd1;
                    gap_d   = 1'b0;
                end
            end
            StGap: begin
                if (gap_q) begin
                    state_d     = StFetch;
                    rd_en_d     = 1'b1;
                    rd_addr_d   = LSE_ADDR_WIDTH'(SYM_BASE[sym_q]);
                    fetch_cnt_d = '0;
                    out_cnt_d   = '0;
                end else begin
                    gap_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                sym_d   = 2'd0;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            sym_q       <= 2'd0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            fetch_cnt_q <= '0;
            out_cnt_q   <= '0;
            eq_addr_q   <= '0;
            gap_q       <= 1'b0;
            in_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_q       <= sym_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            fetch_cnt_q <= fetch_cnt_d;
            out_cnt_q   <= out_cnt_d;
            eq_addr_q   <= eq_addr_d;
            gap_q       <= gap_d;
            in_valid_q  <= rd_en_q;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign lse_rd_en       = rd_en_q;
    assign lse_rd_addr     = rd_addr_q;
    assign mmse_in_valid   = in_valid_q;
    assign mmse_h_i        = in_valid_q ? lse_rd_i : '0;
    assign mmse_h_q        = in_valid_q ? lse_rd_q : '0;
    assign mmse_symbol_num = sym_q;
    assign eq_wr_en        = wr_en;
    assign eq_wr_addr      = eq_addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;

endmodule

// File: tb/tb_mmse_scheduler.sv
// tb_mmse_scheduler: scoreboard bench for mmse_scheduler. Stimulus pushes expected read
// addresses, engine samples, write addresses and done events; a negedge monitor pops and
// compares whenever the DUT presents the corresponding strobe.
module tb_mmse_scheduler;

    localparam int TMO = 100;

    typedef struct {
        logic [7:0] i;
        logic [7:0] q;
        logic [1:0] sym;
    } in_exp_t;

    typedef struct {
        int   cyc;
        logic err;
    } done_exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] lse_rd_i = 8'd0;
    logic [7:0] lse_rd_q = 8'd0;
    logic       mmse_out_valid = 1'b0;
    logic       mmse_symbol_done = 1'b0;
    logic       lse_rd_en;
    logic [7:0] lse_rd_addr;
    logic [7:0] mmse_h_i, mmse_h_q;
    logic       mmse_in_valid;
    logic [1:0] mmse_symbol_num;
    logic       eq_wr_en;
    logic [9:0] eq_wr_addr;
    logic       busy, done, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int        base_t [4] = '{0, 60, 72, 84};
    int        len_t  [4] = '{60, 12, 12, 60};
    int        addr_exp[$];
    in_exp_t   in_exp[$];
    int        eq_exp[$];
    done_exp_t done_exp[$];

    mmse_scheduler #(
        .LSE_WORD_LENGTH(8),
        .LSE_ADDR_WIDTH (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .lse_rd_en       (lse_rd_en),
        .lse_rd_addr     (lse_rd_addr),
        .lse_rd_i        (lse_rd_i),
        .lse_rd_q        (lse_rd_q),
        .mmse_h_i        (mmse_h_i),
        .mmse_h_q        (mmse_h_q),
        .mmse_in_valid   (mmse_in_valid),
        .mmse_symbol_num (mmse_symbol_num),
        .mmse_out_valid  (mmse_out_valid),
        .mmse_symbol_done(mmse_symbol_done),
        .eq_wr_en        (eq_wr_en),
        .eq_wr_addr      (eq_wr_addr),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // LSE buffer model: synchronous read, content derived from the address.
    always @(posedge clk) begin
        if (lse_rd_en) begin
            lse_rd_i <= lse_rd_addr ^ 8'h5A;
            lse_rd_q <= ~lse_rd_addr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic no_exp(input string name);
        checks++;
        errors++;
        $display("FAIL %s: strobe with no expectation (cycle %0d)", name, cyc);
    endtask

    // Monitor
    int        m_a;
    in_exp_t   m_e;
    done_exp_t m_d;
    always @(negedge clk) begin
        if (rst) begin
            if (lse_rd_en) begin
                if (addr_exp.size() == 0) no_exp("lse_rd_unexpected");
                else begin
                    m_a = addr_exp.pop_front();
                    chk("lse_rd_addr", 32'(lse_rd_addr), 32'(m_a));
                end
            end
            if (mmse_in_valid) begin
                if (in_exp.size() == 0) no_exp("mmse_in_unexpected");
                else begin
                    m_e = in_exp.pop_front();
                    chk("mmse_h_i", 32'(mmse_h_i), 32'(m_e.i));
                    chk("mmse_h_q", 32'(mmse_h_q), 32'(m_e.q));
                    chk("mmse_symbol_num", 32'(mmse_symbol_num), 32'(m_e.sym));
                end
            end else begin
                chk("mmse_h_idle", {16'd0, mmse_h_i, mmse_h_q}, 32'd0);
            end
            if (eq_wr_en) begin
                if (eq_exp.size() == 0) no_exp("eq_wr_unexpected");
                else begin
                    m_a = eq_exp.pop_front();
                    chk("eq_wr_addr", 32'(eq_wr_addr), 32'(m_a));
                end
            end
            if (done) begin
                if (done_exp.size() == 0) no_exp("done_unexpected");
                else begin
                    m_d = done_exp.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(m_d.cyc));
                    chk("err_at_done", 32'(err), 32'(m_d.err));
                    chk("busy_at_done", 32'(busy), 32'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_valid(input logic lvl);
        for (int k = 0; k < 300; k++) begin
            if (mmse_in_valid === lvl) return;
            tick();
        end
        chk("wait_in_valid_timeout", 32'(mmse_in_valid), 32'(lvl));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_lse_rd_en"}, 32'(lse_rd_en), 32'd0);
        chk({tag, "_lse_rd_addr"}, 32'(lse_rd_addr), 32'd0);
        chk({tag, "_mmse_h"}, {16'd0, mmse_h_i, mmse_h_q}, 32'd0);
        chk({tag, "_mmse_in_valid"}, 32'(mmse_in_valid), 32'd0);
        chk({tag, "_symbol_num"}, 32'(mmse_symbol_num), 32'd0);
        chk({tag, "_eq_wr_en"}, 32'(eq_wr_en), 32'd0);
        chk({tag, "_eq_wr_addr"}, 32'(eq_wr_addr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Issue start and queue every expectation for the symbols that will be fetched.
    task automatic start_ssb(input int total_out, input int nsyms, output int t);
        for (int s = 0; s < nsyms; s++) begin
            for (int k = 0; k < len_t[s]; k++) begin
                int a;
                in_exp_t e;
                a = base_t[s] + k;
                addr_exp.push_back(a);
                e.i = 8'(a) ^ 8'h5A;
                e.q = ~8'(a);
                e.sym = 2'(s);
                in_exp.push_back(e);
            end
        end
        for (int n = 0; n < total_out; n++) eq_exp.push_back(n);
        start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("rd_en_at_t1", 32'(lse_rd_en), 32'd1);
        chk("err_cleared_on_start", 32'(err), 32'd0);
    endtask

    // Engine model for one symbol; returns in cycle s+1 where s is the symbol_done cycle.
    task automatic engine_sym(input int sym, input int n_out, input bit done_with_last,
                              input bit stray, input bit start_in_fetch, input logic exp_err,
                              input int eq_so_far);
        int s;
        s = 0;
        wait_in_valid(1'b1);
        if (start_in_fetch) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_in_valid(1'b0);
        for (int j = 0; j < n_out; j++) begin
            mmse_out_valid = 1'b1;
            if (done_with_last && j == n_out - 1) begin
                mmse_symbol_done = 1'b1;
                s = cyc;
            end
            tick();
        end
        mmse_out_valid = 1'b0;
        if (!(done_with_last && n_out > 0)) begin
            mmse_symbol_done = 1'b1;
            s = cyc;
            tick();
        end
        mmse_symbol_done = 1'b0;
        if (sym == 3) begin
            done_exp_t d;
            d.cyc = s + 2;
            d.err = exp_err;
            done_exp.push_back(d);
        end
        if (stray) begin
            tick();
            mmse_out_valid = 1'b1;
            @(negedge clk);
            chk("stray_gap_wr_en_1", 32'(eq_wr_en), 32'd0);
            tick();
            @(negedge clk);
            chk("stray_gap_wr_en_2", 32'(eq_wr_en), 32'd0);
            tick();
            mmse_out_valid = 1'b0;
            chk("stray_gap_eq_addr", 32'(eq_wr_addr), 32'(eq_so_far + n_out));
        end
    endtask

    task automatic end_ssb(input string tag, input int total_out);
        tick();
        tick();
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_eq_addr_final"}, 32'(eq_wr_addr), 32'(total_out));
        chk({tag, "_addr_q_empty"}, 32'(addr_exp.size()), 32'd0);
        chk({tag, "_in_q_empty"}, 32'(in_exp.size()), 32'd0);
        chk({tag, "_eq_q_empty"}, 32'(eq_exp.size()), 32'd0);
        chk({tag, "_done_q_empty"}, 32'(done_exp.size()), 32'd0);
    endtask

    task automatic nominal(input string tag, input bit stray);
        int t;
        start_ssb(576, 4, t);
        engine_sym(0, 240, 1'b0, stray, 1'b0, 1'b0, 0);
        engine_sym(1, 48, 1'b0, 1'b0, 1'b0, 1'b0, 240);
        engine_sym(2, 48, 1'b1, 1'b0, 1'b0, 1'b0, 288);
        engine_sym(3, 240, 1'b1, 1'b0, 1'b0, 1'b0, 336);
        end_ssb(tag, 576);
    endtask

    initial begin
        int t;
        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Nominal SSB with stray engine strobes during the first GAP.
        nominal("nominal", 1'b1);

        // Short symbol 1 (47 outputs): err sets after CHECK, SSB still completes.
        start_ssb(575, 4, t);
        engine_sym(0, 240, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        engine_sym(1, 47, 1'b0, 1'b0, 1'b0, 1'b1, 240);
        tick();
        chk("err_after_short_check", 32'(err), 32'd1);
        engine_sym(2, 48, 1'b0, 1'b0, 1'b0, 1'b1, 287);
        engine_sym(3, 240, 1'b0, 1'b0, 1'b0, 1'b1, 335);
        end_ssb("short", 575);

        // start during symbol 2 FETCH and in the DONE cycle must both be ignored.
        start_ssb(576, 4, t);
        engine_sym(0, 240, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        engine_sym(1, 48, 1'b0, 1'b0, 1'b0, 1'b0, 240);
        engine_sym(2, 48, 1'b0, 1'b0, 1'b1, 1'b0, 288);
        engine_sym(3, 240, 1'b0, 1'b0, 1'b0, 1'b0, 336);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_done_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 5; k++) tick();
        chk("start_in_done_no_fetch", 32'(lse_rd_en), 32'd0);
        chk("start_in_done_addr_q", 32'(addr_exp.size()), 32'd0);
        chk("start_in_done_done_q", 32'(done_exp.size()), 32'd0);

        // Reset in the middle of symbol 0 WAIT, then a clean restart.
        start_ssb(576, 4, t);
        wait_in_valid(1'b1);
        wait_in_valid(1'b0);
        for (int k = 0; k < 5; k++) begin
            mmse_out_valid = 1'b1;
            tick();
        end
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        addr_exp.delete();
        in_exp.delete();
        eq_exp.delete();
        done_exp.delete();
        tick();
        mmse_out_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_symbol_num", 32'(mmse_symbol_num), 32'd0);
        nominal("restart", 1'b0);

        // Engine never signals symbol_done.
        start_ssb(0, 1, t);
`ifdef MMSE_SCHED_TIMEOUT_EN
        begin
            done_exp_t d;
            d.cyc = t + 62 + TMO;
            d.err = 1'b1;
            done_exp.push_back(d);
        end
        for (int k = 0; k < TMO + 300 && cyc < t + 63 + TMO; k++) tick();
        chk("timeout_busy_low", 32'(busy), 32'd0);
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_done_q", 32'(done_exp.size()), 32'd0);
`else
        for (int k = 0; k < 10000; k++) tick();
        chk("hang_still_busy", 32'(busy), 32'd1);
        chk("hang_err_clear", 32'(err), 32'd0);
        chk("hang_done_q", 32'(done_exp.size()), 32'd0);
`endif
        chk("hang_addr_q", 32'(addr_exp.size()), 32'd0);
        chk("hang_in_q", 32'(in_exp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
